// File: rtl/full_handshake_tx_fifo.sv
// Queued four-phase (req/ack) transmitter. Words enter through a valid/ready
// port and are sent one at a time over a synchronised full handshake.
module full_handshake_tx_fifo #(
  parameter int DW          = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_i,
  input  logic [DW-1:0]          in_data_i,
  output logic                   in_ready_o,
  input  logic                   ack_i,
  output logic                   req_o,
  output logic [DW-1:0]          req_data_o,
  output logic                   idle_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   ack_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    DEASSERT = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic [DW-1:0]          mem [DEPTH];
  logic [AW-1:0]          rd_ptr, wr_ptr;
  logic [CW-1:0]          count;
  logic                   push, pop, req_nxt, err_set;

  // ack_i is asynchronous; only the last stage of this chain is ever used.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], ack_i};
  end

  assign ack_s      = sync_q[SYNC_STAGES-1];
  assign in_ready_o = (count != FULL);
  assign push       = in_valid_i && in_ready_o;
  assign idle_o     = (state == IDLE) && (count == '0);
  assign level_o    = count;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    req_nxt   = req_o;
    pop       = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (ack_s) begin
          err_set = 1'b1;
        end else if (count != '0) begin
          pop       = 1'b1;
          req_nxt   = 1'b1;
          state_nxt = ASSERT;
        end
      end
      ASSERT: begin
        if (ack_s) begin
          req_nxt   = 1'b0;
          state_nxt = DEASSERT;
        end
      end
      DEASSERT: begin
        if (!ack_s) state_nxt = IDLE;
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_o      <= 1'b0;
      req_data_o <= '0;
      ack_err_o  <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      state <= state_nxt;
      req_o <= req_nxt;
      if (pop) begin
        req_data_o <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + AW'(1);
      end
      if (push)    wr_ptr    <= wr_ptr + AW'(1);
      if (err_set) ack_err_o <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the storage array is not reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data_i;
  end

endmodule
